// File: rtl/pulse_sched_pkg.sv
// Shared defaults and types for the pulse-count scheduler.
package pulse_sched_pkg;

  localparam int unsigned NCH_DEF = 8;
  localparam int unsigned CW_DEF  = 8;
  localparam int unsigned IW_DEF  = $clog2(NCH_DEF);

  typedef logic [IW_DEF-1:0] ch_idx_t;
  typedef logic [CW_DEF-1:0] count_t;

  localparam count_t COUNT_MAX = '1;

endpackage

// File: rtl/pulse_count_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, cyclically.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  localparam int unsigned IW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [NCH-1:0] req,
  output logic           gnt_vld,
  output logic [IW-1:0]  gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  // NCH is a power of two, so the IW-bit add wraps cyclically for free.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = ptr_q + i[IW-1:0];
      if (en && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Pointer moves just past the last granted channel; idle cycles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      ptr_q <= gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_count_scheduler.sv
// Multichannel pulse-counting scheduler: synchronises pulse inputs, queues
// rising edges as pending events and services them through one shared
// incrementer via a round-robin arbiter.
// Optional feature macro: PULSE_SCHED_LOST_EN (sticky lost-event flags).
module pulse_count_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned CW  = CW_DEF,
  localparam int unsigned IW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [NCH-1:0] ch_in,
  input  logic           clr,
  input  logic [IW-1:0]  clr_sel,
  input  logic [IW-1:0]  rd_sel,
  output logic [CW-1:0]  rd_data,
  output logic [NCH-1:0] sat,
  output logic [NCH-1:0] lost,
  output logic           busy
);

  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic [NCH-1:0] s1_q, s2_q, s3_q;
  logic [NCH-1:0] edge_det;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] gnt_oh;
  logic [NCH-1:0] sat_q;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  rd_q;
  logic           gnt_vld;
  logic [IW-1:0]  gnt_idx;

  // Two-flop synchroniser plus history flop; runs regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= ch_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det = s2_q & ~s3_q;

  rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ena),
    .req     (pend_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // One-hot grant and pending next state; a new edge on the granted channel re-arms it.
  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
    pend_d = (pend_q & ~gnt_oh) | (edge_det & {NCH{ena}});
  end

  // Pending-event register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Count and saturation update; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c] <= '0;
      end
      sat_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clr && (clr_sel == c[IW-1:0])) begin
          cnt_q[c] <= '0;
          sat_q[c] <= 1'b0;
        end else if (gnt_oh[c]) begin
          if (cnt_q[c] == CntMax) begin
            sat_q[c] <= 1'b1;
          end else begin
            cnt_q[c] <= cnt_q[c] + CntOne;
          end
        end
      end
    end
  end

`ifdef PULSE_SCHED_LOST_EN
  logic [NCH-1:0] lost_q;
  logic [NCH-1:0] lost_set;

  // An accepted edge finding its channel already pending (and not served now) is dropped.
  assign lost_set = edge_det & {NCH{ena}} & pend_q & ~gnt_oh;

  // Sticky lost flags, cleared together with the channel count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clr && (clr_sel == c[IW-1:0])) begin
          lost_q[c] <= 1'b0;
        end else if (lost_set[c]) begin
          lost_q[c] <= 1'b1;
        end
      end
    end
  end

  assign lost = lost_q;
`else
  assign lost = '0;
`endif

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= cnt_q[rd_sel];
    end
  end

  assign rd_data = rd_q;
  assign sat     = sat_q;
  assign busy    = |pend_q;

endmodule

// File: tb/tb_pulse_count_scheduler.sv
// Directed self-checking bench for pulse_count_scheduler (NCH=8, CW=8).
module tb_pulse_count_scheduler;
  import pulse_sched_pkg::*;

  localparam int unsigned NCH = 8;
  localparam int unsigned CW  = 8;

`ifdef PULSE_SCHED_LOST_EN
  localparam bit LostOn = 1'b1;
`else
  localparam bit LostOn = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           ena;
  logic [NCH-1:0] ch_in;
  logic           clr;
  logic [2:0]     clr_sel;
  logic [2:0]     rd_sel;
  logic [CW-1:0]  rd_data;
  logic [NCH-1:0] sat;
  logic [NCH-1:0] lost;
  logic           busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pulse_count_scheduler #(
    .NCH (NCH),
    .CW  (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ch_in   (ch_in),
    .clr     (clr),
    .clr_sel (clr_sel),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .sat     (sat),
    .lost    (lost),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    ch_in   = '0;
    clr     = 1'b0;
    clr_sel = '0;
    rd_sel  = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of activity
    ch_in = 8'hFF; tick();           // edge k
    ch_in = 8'h00; tick(); tick();   // k+2: all pending
    check("pend_all", dut.pend_q, 32'hFF);
    tick();                          // ch0 granted
    check("cnt0_pre_rst", dut.cnt_q[0], 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ptr", dut.u_arb.ptr_q, 32'd0);
    check("rst_cnt0", dut.cnt_q[0], 32'd0);
    check("rst_pend", dut.pend_q, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      rd_sel = c[2:0];
      tick();
      check($sformatf("rst_read_ch%0d", c), rd_data, 32'd0);
    end

    // Single pulse on ch3: latency k+2 pend, k+3 count, k+4 rd_data
    rd_sel = 3'd3;
    ch_in = 8'h08; tick();           // k
    ch_in = 8'h00; tick();           // k+1
    check("ch3_busy_k1", busy, 32'd0);
    tick();                          // k+2
    check("ch3_busy_k2", busy, 32'd1);
    tick();                          // k+3
    check("ch3_cnt_k3", dut.cnt_q[3], 32'd1);
    check("ch3_rd_k3", rd_data, 32'd0);
    tick();                          // k+4
    check("ch3_rd_k4", rd_data, 32'd1);
    for (int c = 0; c < NCH; c++) begin
      rd_sel = c[2:0];
      tick();
      check($sformatf("ch3_read_ch%0d", c), rd_data, (c == 3) ? 32'd1 : 32'd0);
    end

    // Simultaneous edges on 0, 5, 7 from ptr=0
    do_reset();
    check("rr_ptr_start", dut.u_arb.ptr_q, 32'd0);
    ch_in = 8'hA1; tick();
    ch_in = 8'h00; tick(); tick();
    check("rr_pend0", dut.pend_q, 32'hA1);
    tick();
    check("rr_ptr_g0", dut.u_arb.ptr_q, 32'd1);
    check("rr_pend_g0", dut.pend_q, 32'hA0);
    tick();
    check("rr_ptr_g5", dut.u_arb.ptr_q, 32'd6);
    check("rr_pend_g5", dut.pend_q, 32'h80);
    tick();
    check("rr_ptr_g7", dut.u_arb.ptr_q, 32'd0);
    check("rr_pend_g7", dut.pend_q, 32'h00);
    // Second burst on 0 and 5; ptr wrapped to 0, so 0 goes first
    ch_in = 8'h21; tick();
    ch_in = 8'h00; tick(); tick();
    check("rr2_pend", dut.pend_q, 32'h21);
    tick();
    check("rr2_ptr_g0", dut.u_arb.ptr_q, 32'd1);
    tick();
    check("rr2_ptr_g5", dut.u_arb.ptr_q, 32'd6);
    check("rr2_busy", busy, 32'd0);
    check("rr_cnt0", dut.cnt_q[0], 32'd2);
    check("rr_cnt5", dut.cnt_q[5], 32'd2);
    check("rr_cnt7", dut.cnt_q[7], 32'd1);

    // Saturation on ch1
    rd_sel = 3'd1;
    repeat (255) begin
      ch_in = 8'h02; tick();
      ch_in = 8'h00; tick();
    end
    repeat (4) tick();
    check("sat_rd_255", rd_data, 32'(COUNT_MAX));
    check("sat_flag_pre", sat, 32'h00);
    ch_in = 8'h02; tick();
    ch_in = 8'h00; tick();
    repeat (4) tick();
    check("sat_rd_hold", rd_data, 32'd255);
    check("sat_flag_set", sat, 32'h02);
    clr_sel = 3'd1;
    clr = 1'b1; tick();
    clr = 1'b0;
    check("sat_clr_flag", sat, 32'h00);
    check("sat_clr_cnt", dut.cnt_q[1], 32'd0);
    tick();
    check("sat_clr_rd", rd_data, 32'd0);

    // ena=0 holds a pending event and ignores further edges
    ch_in = 8'h04; tick();
    ch_in = 8'h00; tick(); tick();   // k+2: pend[2] set
    ena = 1'b0;
    repeat (2) begin
      ch_in = 8'h04; tick();
      ch_in = 8'h00; tick();
    end
    repeat (4) tick();
    check("ena0_busy", busy, 32'd1);
    check("ena0_pend", dut.pend_q, 32'h04);
    check("ena0_cnt2", dut.cnt_q[2], 32'd0);
    ena = 1'b1;
    tick();
    check("ena1_cnt2", dut.cnt_q[2], 32'd1);
    check("ena1_busy", busy, 32'd0);
    repeat (6) tick();
    check("ena1_cnt2_hold", dut.cnt_q[2], 32'd1);
    check("ena1_lost", lost, 32'h00);

    // Overrun on ch2 while queued behind ch0 and ch1
    ch_in = 8'h07; tick();           // k
    ch_in = 8'h00; tick();           // k+1
    ch_in = 8'h04; tick();           // k+2: pend 0,1,2
    ch_in = 8'h00;
    check("ovr_pend", dut.pend_q, 32'h07);
    tick();                          // k+3: ch0 served
    check("ovr_pend_g0", dut.pend_q, 32'h06);
    tick();                          // k+4: ch1 served, ch2 edge dropped
    check("ovr_pend_g1", dut.pend_q, 32'h04);
    tick();                          // k+5: ch2 served
    check("ovr_cnt2", dut.cnt_q[2], 32'd2);
    check("ovr_lost", lost, LostOn ? 32'h04 : 32'h00);
    clr_sel = 3'd2;
    clr = 1'b1; tick();
    clr = 1'b0;
    check("ovr_lost_clr", lost, 32'h00);
    check("ovr_cnt_clr", dut.cnt_q[2], 32'd0);

    // Clear collides with grant on ch4
    ch_in = 8'h10; tick();
    ch_in = 8'h00; repeat (4) tick();
    check("col_cnt4_pre", dut.cnt_q[4], 32'd1);
    ch_in = 8'h10; tick();
    ch_in = 8'h00; tick(); tick();   // k+2: pend[4]
    check("col_pend_pre", dut.pend_q, 32'h10);
    clr_sel = 3'd4;
    clr = 1'b1; tick();              // k+3: grant and clear together
    clr = 1'b0;
    check("col_cnt4", dut.cnt_q[4], 32'd0);
    check("col_pend", dut.pend_q, 32'h00);
    rd_sel = 3'd4;
    tick();
    check("col_rd4", rd_data, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
